// File: rtl/tdc_fine_encoder.sv
// Single-channel TDC hit encoder: thermometer snapshot -> edge detect ->
// popcount fine time -> coarse-tagged word queued behind a valid/ready FIFO.
module tdc_fine_encoder #(
    parameter int NTAPS    = 32,
    parameter int CW       = 16,
    parameter int DEPTH    = 4,
    parameter int DEADTIME = 2,
    localparam int FW      = $clog2(NTAPS + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NTAPS-1:0] therm,
    input  logic             en,
    input  logic [1:0]       edge_sel,
    input  logic             clr_ovf,
    output logic             hit_valid,
    input  logic             hit_ready,
    output logic             hit_edge,
    output logic [CW-1:0]    hit_coarse,
    output logic [FW-1:0]    hit_fine,
    output logic             ovf
);

    localparam int DW = (DEADTIME > 0) ? $clog2(DEADTIME + 1) : 1;
    localparam int AW = $clog2(DEPTH);
    localparam int WW = 1 + CW + FW;
    localparam logic [DW-1:0] DEAD_INIT = DW'(DEADTIME);
    localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(DEPTH);

    function automatic logic [FW-1:0] popcount(input logic [NTAPS-1:0] v);
        logic [FW-1:0] n;
        n = '0;
        for (int i = 0; i < NTAPS; i++) begin
            n = n + FW'(v[i]);
        end
        return n;
    endfunction

    // capture stage
    logic [CW-1:0]    coarse_q, coarse_d;
    logic [NTAPS-1:0] s_q, s_d;
    logic [NTAPS-1:0] s_qq, s_qq_d;
    logic [CW-1:0]    cap_coarse_q, cap_coarse_d;

    // detect stage
    logic             rise, fall, accept;
    logic [DW-1:0]    dead_q, dead_d;
    logic             d_valid_q, d_valid_d;
    logic             d_edge_q, d_edge_d;
    logic [CW-1:0]    d_coarse_q, d_coarse_d;
    logic [NTAPS-1:0] d_snap_q, d_snap_d;

    // encode stage
    logic             e_valid_q, e_valid_d;
    logic             e_edge_q, e_edge_d;
    logic [CW-1:0]    e_coarse_q, e_coarse_d;
    logic [FW-1:0]    e_fine_q, e_fine_d;

    // write stage
    logic             w_valid_q, w_valid_d;
    logic [WW-1:0]    w_word_q, w_word_d;

    // output FIFO
    logic [WW-1:0]    mem_q [DEPTH];
    logic [WW-1:0]    mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             pop, push, drop, room;

    always_comb begin
        coarse_d     = coarse_q + CW'(1);
        s_d          = therm;
        s_qq_d       = s_q;
        cap_coarse_d = coarse_q;
    end

    // tap0 of the newest snapshot against the last tap of the previous one
    assign rise   = s_q[0] & ~s_qq[NTAPS-1];
    assign fall   = ~s_q[0] & s_qq[NTAPS-1];
    assign accept = en & ((rise & edge_sel[0]) | (fall & edge_sel[1]))
                  & (dead_q == '0);

    always_comb begin
        dead_d     = dead_q;
        d_valid_d  = accept;
        d_edge_d   = rise;
        d_coarse_d = cap_coarse_q;
        d_snap_d   = s_q;
        if (accept) begin
            dead_d = DEAD_INIT;
        end else if (dead_q != '0) begin
            dead_d = dead_q - DW'(1);
        end
    end

    // counting instead of priority-encoding absorbs bubbles
    always_comb begin
        e_valid_d  = d_valid_q;
        e_edge_d   = d_edge_q;
        e_coarse_d = d_coarse_q;
        e_fine_d   = popcount(d_edge_q ? d_snap_q : ~d_snap_q);
    end

    always_comb begin
        w_valid_d = e_valid_q;
        w_word_d  = {e_edge_q, e_coarse_q, e_fine_q};
    end

    assign hit_valid = (cnt_q != '0);
    assign pop       = hit_valid & hit_ready;
    assign room      = (cnt_q != FULL_CNT) | pop;
    assign push      = w_valid_q & room;
    assign drop      = w_valid_q & ~room;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        if (push) begin
            mem_d[wr_ptr_q] = w_word_q;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + (AW + 1)'(1);
            2'b01:   cnt_d = cnt_q - (AW + 1)'(1);
            default: cnt_d = cnt_q;
        endcase
        // a drop in the same cycle as the clear keeps the flag set
        if (drop) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            coarse_q     <= '0;
            s_q          <= '0;
            s_qq         <= '0;
            cap_coarse_q <= '0;
            dead_q       <= '0;
            d_valid_q    <= 1'b0;
            d_edge_q     <= 1'b0;
            d_coarse_q   <= '0;
            d_snap_q     <= '0;
            e_valid_q    <= 1'b0;
            e_edge_q     <= 1'b0;
            e_coarse_q   <= '0;
            e_fine_q     <= '0;
            w_valid_q    <= 1'b0;
            w_word_q     <= '0;
            mem_q        <= '{default: '0};
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            cnt_q        <= '0;
            ovf_q        <= 1'b0;
        end else begin
            coarse_q     <= coarse_d;
            s_q          <= s_d;
            s_qq         <= s_qq_d;
            cap_coarse_q <= cap_coarse_d;
            dead_q       <= dead_d;
            d_valid_q    <= d_valid_d;
            d_edge_q     <= d_edge_d;
            d_coarse_q   <= d_coarse_d;
            d_snap_q     <= d_snap_d;
            e_valid_q    <= e_valid_d;
            e_edge_q     <= e_edge_d;
            e_coarse_q   <= e_coarse_d;
            e_fine_q     <= e_fine_d;
            w_valid_q    <= w_valid_d;
            w_word_q     <= w_word_d;
            mem_q        <= mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            cnt_q        <= cnt_d;
            ovf_q        <= ovf_d;
        end
    end

    assign {hit_edge, hit_coarse, hit_fine} = mem_q[rd_ptr_q];
    assign ovf = ovf_q;

endmodule

// File: tb/tb_tdc_fine_encoder.sv
// Bench for tdc_fine_encoder: directed scenarios with literal expectations,
// then randomized traffic against a queue-based reference model.
module tb_tdc_fine_encoder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] therm = '0;
    logic        en = 1'b1;
    logic [1:0]  edge_sel = 2'b01;
    logic        clr_ovf = 1'b0;
    logic        hit_valid;
    logic        hit_ready = 1'b0;
    logic        hit_edge;
    logic [15:0] hit_coarse;
    logic [5:0]  hit_fine;
    logic        ovf;

    tdc_fine_encoder #(
        .NTAPS(32), .CW(16), .DEPTH(4), .DEADTIME(2)
    ) dut (
        .clk(clk), .reset(reset), .therm(therm), .en(en),
        .edge_sel(edge_sel), .clr_ovf(clr_ovf),
        .hit_valid(hit_valid), .hit_ready(hit_ready),
        .hit_edge(hit_edge), .hit_coarse(hit_coarse),
        .hit_fine(hit_fine), .ovf(ovf)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    typedef struct {
        int due;
        bit e;
        int c;
        int f;
    } hit_t;

    hit_t        pend[$];
    hit_t        fifo[$];
    int          cyc;
    bit [31:0]   m_s;
    bit [31:0]   m_sp;
    int          m_capc;
    int          m_coarse;
    int          m_dead;
    bit          m_ovf;

    function automatic int popcnt(input bit [31:0] v);
        int n = 0;
        for (int i = 0; i < 32; i++) n += int'(v[i]);
        return n;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference: inputs sampled at a clock edge update the abstract state.
    task automatic model_edge();
        hit_t h;
        bit   rise, fall, acc;
        if (reset) begin
            pend.delete();
            fifo.delete();
            cyc = 0; m_s = '0; m_sp = '0; m_capc = 0;
            m_coarse = 0; m_dead = 0; m_ovf = 0;
            return;
        end
        if (fifo.size() > 0 && hit_ready) void'(fifo.pop_front());
        if (clr_ovf) m_ovf = 0;
        while (pend.size() > 0 && pend[0].due == cyc) begin
            h = pend.pop_front();
            if (fifo.size() < 4) fifo.push_back(h);
            else m_ovf = 1;
        end
        rise = m_s[0] && !m_sp[31];
        fall = !m_s[0] && m_sp[31];
        acc = en && ((rise && edge_sel[0]) || (fall && edge_sel[1])) && m_dead == 0;
        if (acc) begin
            h.due = cyc + 3;
            h.e = rise;
            h.c = m_capc;
            h.f = rise ? popcnt(m_s) : popcnt(~m_s);
            pend.push_back(h);
            m_dead = 2;
        end else if (m_dead > 0) begin
            m_dead--;
        end
        m_sp = m_s;
        m_s = therm;
        m_capc = m_coarse;
        m_coarse = (m_coarse + 1) % 65536;
        cyc++;
    endtask

    task automatic compare();
        chk("valid", hit_valid, fifo.size() > 0);
        chk("ovf", ovf, m_ovf);
        if (fifo.size() > 0) begin
            chk("edge", hit_edge, fifo[0].e);
            chk("coarse", hit_coarse, fifo[0].c);
            chk("fine", hit_fine, fifo[0].f);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare();
    endtask

    function automatic logic [31:0] rand_therm();
        int          n;
        logic [63:0] t;
        logic [31:0] v;
        n = $urandom_range(0, 32);
        t = (64'd1 << n) - 64'd1;
        v = t[31:0];
        case ($urandom_range(0, 3))
            0: v = v;
            1: v = ~v;
            2: v = v ^ (32'd1 << $urandom_range(0, 31));
            default: v = $urandom;
        endcase
        return v;
    endfunction

    int cap;
    int seen;
    int got[$];
    int hold;

    initial begin
        // reset state
        step(); step();
        chk("rst_valid", hit_valid, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_edge", hit_edge, 0);
        chk("rst_coarse", hit_coarse, 0);
        chk("rst_fine", hit_fine, 0);

        // T1 rising hit captured at coarse 10
        reset = 0; therm = '0; edge_sel = 2'b01; hit_ready = 0;
        for (int i = 0; i < 10; i++) step();
        therm = 32'h0000_00FF;
        step();
        therm = 32'hFFFF_FFFF;
        step(); step(); step();
        chk("t1_latency", hit_valid, 0);
        step();
        chk("t1_valid", hit_valid, 1);
        chk("t1_edge", hit_edge, 1);
        chk("t1_coarse", hit_coarse, 10);
        chk("t1_fine", hit_fine, 8);
        hit_ready = 1;
        step();

        // T2 falling hit; steady all-ones gives nothing
        edge_sel = 2'b10;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (hit_valid) seen++;
        end
        chk("t2_steady", seen, 0);
        therm = 32'hFFFF_0000;
        cap = cyc;
        step();
        therm = '0;
        step(); step(); step();
        chk("t2_latency", hit_valid, 0);
        step();
        chk("t2_valid", hit_valid, 1);
        chk("t2_edge", hit_edge, 0);
        chk("t2_coarse", hit_coarse, cap);
        chk("t2_fine", hit_fine, 16);

        // T3 bubble, then no edges accepted at all
        edge_sel = 2'b01;
        for (int i = 0; i < 4; i++) step();
        therm = 32'h0000_00F7;
        cap = cyc;
        step();
        therm = 32'hFFFF_FFFF;
        for (int i = 0; i < 4; i++) step();
        chk("t3_valid", hit_valid, 1);
        chk("t3_fine", hit_fine, 7);
        chk("t3_coarse", hit_coarse, cap);
        for (int i = 0; i < 3; i++) step();
        edge_sel = 2'b00;
        seen = 0;
        for (int i = 0; i < 16; i++) begin
            therm = (i % 3 == 0) ? 32'h0 : (i % 3 == 1) ? 32'hFF : 32'hFFFF_FFFF;
            step();
            if (hit_valid) seen++;
        end
        chk("t3_nosel", seen, 0);

        // T4 overflow then ordered drain
        edge_sel = 2'b01; therm = '0;
        for (int i = 0; i < 4; i++) step();
        hit_ready = 0;
        for (int k = 0; k < 5; k++) begin
            therm = 32'hFFFF_FFFF >> (32 - (3 + 2 * k));
            step();
            therm = '0;
            step(); step(); step();
        end
        step(); step(); step();
        chk("t4_valid", hit_valid, 1);
        chk("t4_ovf", ovf, 1);
        hit_ready = 1;
        got.delete();
        for (int i = 0; i < 8; i++) begin
            if (hit_valid) got.push_back(int'(hit_fine));
            step();
        end
        chk("t4_count", got.size(), 4);
        for (int i = 0; i < got.size() && i < 4; i++)
            chk("t4_order", got[i], 3 + 2 * i);
        chk("t4_ovf_hold", ovf, 1);
        clr_ovf = 1;
        step();
        clr_ovf = 0;
        chk("t4_clr", ovf, 0);

        // T5 dead time: 2 cycles apart blocked, 3 cycles apart accepted
        therm = '0;
        for (int i = 0; i < 4; i++) step();
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            therm = (i == 1 || i == 3) ? 32'hFF : 32'h0;
            step();
            if (hit_valid && hit_ready) seen++;
        end
        chk("t5_close", seen, 1);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            therm = (i == 1 || i == 4) ? 32'hFF : 32'h0;
            step();
            if (hit_valid && hit_ready) seen++;
        end
        chk("t5_apart", seen, 2);
        chk("t5_ovf", ovf, 0);

        // T6 reset with words queued
        hit_ready = 0;
        for (int k = 0; k < 2; k++) begin
            therm = 32'hFF; step();
            therm = '0; step(); step(); step();
        end
        step(); step();
        chk("t6_queued", hit_valid, 1);
        reset = 1;
        step();
        chk("t6_valid", hit_valid, 0);
        chk("t6_ovf", ovf, 0);
        reset = 0; hit_ready = 1;
        step(); step(); step();
        therm = 32'h0000_FFFF;
        step();
        therm = '0;
        step(); step(); step(); step();
        chk("t6_valid2", hit_valid, 1);
        chk("t6_coarse", hit_coarse, 3);
        chk("t6_fine", hit_fine, 16);

        // randomized traffic
        hold = 0;
        for (int i = 0; i < 3000; i++) begin
            if (hold == 0) begin
                therm = rand_therm();
                hold = $urandom_range(1, 5);
            end
            hold--;
            en = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 19) == 0) edge_sel = 2'($urandom_range(0, 3));
            hit_ready = ($urandom_range(0, 3) != 0);
            clr_ovf = ($urandom_range(0, 24) == 0);
            reset = ($urandom_range(0, 399) == 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
